user_sdram_bridge: RTL

- Sits directly downstream of the user TFT command/control block and upstream of the SDRAM controller.
- Takes the single-word user write holding register (FIFO_full/FIFO_data) and user read requests (FIFO_WR_req), and turns them into word accesses on the SDRAM controller's req/ack port.
- Builds each access address from the current page/row/column pointers.
- Pulses startup_inc after each completed access so the user row/column counters advance.

---
 rtl/user_sdram_pkg.sv | 27 ++
 rtl/user_sdram_bridge_if.sv | 39 +++
 rtl/bridge_rd_watchdog.sv | 28 ++
 rtl/user_sdram_bridge.sv | 138 +++++++++++++
 4 files changed

// File: rtl/user_sdram_pkg.sv
// Shared types and constants for the user-to-SDRAM word bridge.
package user_sdram_pkg;

    localparam int unsigned PAGE_W          = 3;
    localparam int unsigned ROW_W           = 9;
    localparam int unsigned COL_W           = 10;
    localparam int unsigned ADDR_W          = PAGE_W + ROW_W + COL_W;
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrRel,
        StRdReq,
        StRdWait
    } bridge_state_e;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [PAGE_W-1:0] page,
                                                    input logic [ROW_W-1:0]  row,
                                                    input logic [COL_W-1:0]  col);
        return {page, row, col};
    endfunction

endpackage

// File: rtl/user_sdram_bridge_if.sv
// Signal bundle between the user TFT block, the bridge and the SDRAM controller port.
interface user_sdram_bridge_if;
    import user_sdram_pkg::*;

    logic [PAGE_W-1:0] page_set;
    logic [ROW_W-1:0]  row_add;
    logic [COL_W-1:0]  col_add;
    logic              FIFO_full;
    logic [DATA_W-1:0] FIFO_data;
    logic              FIFO_RD_req;
    logic              FIFO_WR_req;
    logic [DATA_W-1:0] sdram_rq_data;
    logic              SDARM_RRDY;
    logic              startup_inc;
    logic              sdr_req;
    logic              sdr_we;
    logic [ADDR_W-1:0] sdr_addr;
    logic [DATA_W-1:0] sdr_wdata;
    logic              sdr_ack;
    logic              sdr_rvalid;
    logic [DATA_W-1:0] sdr_rdata;
    logic              bridge_err;

    // Upstream user block plus SDRAM controller, seen from outside the bridge.
    modport master (
        output page_set, row_add, col_add, FIFO_full, FIFO_data, FIFO_WR_req,
        output sdr_ack, sdr_rvalid, sdr_rdata,
        input  FIFO_RD_req, sdram_rq_data, SDARM_RRDY, startup_inc,
        input  sdr_req, sdr_we, sdr_addr, sdr_wdata, bridge_err
    );

    modport slave (
        input  page_set, row_add, col_add, FIFO_full, FIFO_data, FIFO_WR_req,
        input  sdr_ack, sdr_rvalid, sdr_rdata,
        output FIFO_RD_req, sdram_rq_data, SDARM_RRDY, startup_inc,
        output sdr_req, sdr_we, sdr_addr, sdr_wdata, bridge_err
    );

endinterface

// File: rtl/bridge_rd_watchdog.sv
// Counts cycles spent waiting for read data; flags expiry after TIMEOUT cycles.
module bridge_rd_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic osc_clk,
    input  logic RST,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;

    // Cleared whenever idle so every wait starts from zero.
    always_ff @(posedge osc_clk or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else if (!run_i) begin
            cnt_q <= '0;
        end else if (!expired_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = run_i && (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/user_sdram_bridge.sv
// Turns user write-word / read requests into SDRAM controller word accesses.
// Optional read watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module user_sdram_bridge
    import user_sdram_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic               osc_clk,
    input logic               RST,
    user_sdram_bridge_if.slave bus
);

    bridge_state_e state_q, state_d;

    logic              cap_wr, cap_rd, wr_done, rd_done;
    logic              req, rd_ack, rd_wait, rd_timeout;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              we_q, rrdy_q, inc_q;

    always_ff @(posedge osc_clk or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // rrdy_q blocks a stale FIFO_WR_req level from starting a second read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (bus.FIFO_full) begin
                    state_d = StWrReq;
                end else if (bus.FIFO_WR_req && !rrdy_q) begin
                    state_d = StRdReq;
                end
            end
            StWrReq:  if (bus.sdr_ack)                   state_d = StWrRel;
            StWrRel:  if (!bus.FIFO_full)                state_d = StIdle;
            StRdReq:  if (bus.sdr_ack)                   state_d = StRdWait;
            StRdWait: if (bus.sdr_rvalid || rd_timeout)  state_d = StIdle;
            default:                                     state_d = StIdle;
        endcase
    end

    always_comb begin
        cap_wr  = 1'b0;
        cap_rd  = 1'b0;
        wr_done = 1'b0;
        rd_done = 1'b0;
        req     = 1'b0;
        rd_ack  = 1'b0;
        rd_wait = 1'b0;
        case (state_q)
            StIdle: begin
                cap_wr = bus.FIFO_full;
                cap_rd = !bus.FIFO_full && bus.FIFO_WR_req && !rrdy_q;
            end
            StWrReq: begin
                req     = 1'b1;
                wr_done = bus.sdr_ack;
            end
            StWrRel: rd_ack = 1'b1;
            StRdReq: req = 1'b1;
            StRdWait: begin
                rd_wait = 1'b1;
                rd_done = bus.sdr_rvalid || rd_timeout;
            end
            default: ;
        endcase
    end

    // Address and write data stay frozen from capture until the access completes.
    always_ff @(posedge osc_clk or negedge RST) begin
        if (!RST) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            rrdy_q  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            if (cap_wr || cap_rd) begin
                addr_q <= pack_addr(bus.page_set, bus.row_add, bus.col_add);
                we_q   <= cap_wr;
            end
            if (cap_wr) begin
                wdata_q <= bus.FIFO_data;
            end
            if (rd_done) begin
                rdata_q <= bus.sdr_rvalid ? bus.sdr_rdata : ERR_DATA;
            end
            rrdy_q <= rd_done;
            inc_q  <= wr_done || rd_done;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    logic err_q;

    bridge_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_rd_watchdog (
        .osc_clk   (osc_clk),
        .RST       (RST),
        .run_i     (rd_wait),
        .expired_o (rd_timeout)
    );

    always_ff @(posedge osc_clk or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else if (rd_done && !bus.sdr_rvalid) begin
            err_q <= 1'b1;
        end
    end

    assign bus.bridge_err = err_q;
`else
    logic unused_timeout;

    assign rd_timeout     = 1'b0;
    assign unused_timeout = ^{TIMEOUT, rd_wait};
    assign bus.bridge_err = 1'b0;
`endif

    assign bus.sdr_req       = req;
    assign bus.sdr_we        = we_q;
    assign bus.sdr_addr      = addr_q;
    assign bus.sdr_wdata     = wdata_q;
    assign bus.FIFO_RD_req   = rd_ack;
    assign bus.sdram_rq_data = rdata_q;
    assign bus.SDARM_RRDY    = rrdy_q;
    assign bus.startup_inc   = inc_q;

endmodule
